// File: rtl/ahb_master_arbiter.sv
// Round-robin AHB bus arbiter.
// Produces a registered one-hot grant plus the address-phase and data-phase
// owner indices for the bus muxes. Fixed-length bursts and locked sequences
// keep the bus until they complete.
module ahb_master_arbiter #(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  localparam int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic                   hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [MW-1:0]          hmaster,
  output logic [MW-1:0]          hmaster_data,
  output logic                   hmastlock
);

  localparam logic [NUM_MASTERS-1:0] ONE_LSB     = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GNT = ONE_LSB << DEFAULT_MASTER;
  localparam logic [MW-1:0]          DEFAULT_IDX = MW'(DEFAULT_MASTER);

  typedef enum logic [0:0] {
    GRANTED = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [4:0]      beat_cnt_r;
  logic [4:0]      beat_next_s;
  logic [MW-1:0]   rr_ptr_r;
  logic [MW-1:0]   grant_idx_s;
  logic [MW-1:0]   cand_s;
  logic [MW-1:0]   win_idx_s;
  logic            win_found_s;
  logic            lock_owner_s;
  logic            is_idle_s;
  logic            is_busy_s;
  logic            is_nonseq_s;
  logic            is_seq_s;
  logic            fixed_burst_s;
  logic            last_beat_s;
  logic            burst_done_s;
  logic            arb_en_s;

  // Index of the set bit in a one-hot vector.
  function automatic logic [MW-1:0] grant_index(input logic [NUM_MASTERS-1:0] g);
    logic [MW-1:0] idx;
    idx = {MW{1'b0}};
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (g[i]) begin
        idx = idx | MW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Remaining beats after the first one for a given HBURST (0 for SINGLE/INCR).
  function automatic logic [4:0] burst_len_m1(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: burst_len_m1 = 5'd3;
      3'd4, 3'd5: burst_len_m1 = 5'd7;
      3'd6, 3'd7: burst_len_m1 = 5'd15;
      default:    burst_len_m1 = 5'd0;
    endcase
  endfunction

  // Decode the bus transfer and derive burst/lock status of the current owner.
  always_comb begin
    grant_idx_s   = grant_index(hgrant);
    lock_owner_s  = hlock[grant_idx_s];
    is_idle_s     = (htrans == 2'd0);
    is_busy_s     = (htrans == 2'd1);
    is_nonseq_s   = (htrans == 2'd2);
    is_seq_s      = (htrans == 2'd3);
    fixed_burst_s = (hburst[2:1] != 2'b00);
    last_beat_s   = is_seq_s && (beat_cnt_r == 5'd1);
    // A burst is over on ERROR, on IDLE, on its final beat, or when no
    // fixed burst is in flight and none is starting.
    burst_done_s  = hresp ||
                    (hready && (is_idle_s || last_beat_s ||
                                ((beat_cnt_r == 5'd0) && !(is_nonseq_s && fixed_burst_s))));
  end

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {MW{1'b0}};
    cand_s      = {MW{1'b0}};
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand_s = MW'((int'(rr_ptr_r) + k) % NUM_MASTERS);
      if (!win_found_s && hbusreq[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next state, next beat count and arbitration enable.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      GRANTED: begin
        if (hready && ((is_nonseq_s && fixed_burst_s && !hresp) || lock_owner_s)) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = GRANTED;
        end
      end
      HOLD: begin
        if (burst_done_s && !lock_owner_s) begin
          state_next_s = GRANTED;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = GRANTED;
    endcase

    // ERROR clears the counter even if a new NONSEQ is on the bus.
    beat_next_s = beat_cnt_r;
    if (hresp) begin
      beat_next_s = 5'd0;
    end else if (hready && is_nonseq_s) begin
      beat_next_s = burst_len_m1(hburst);
    end else if (hready && is_seq_s && (beat_cnt_r != 5'd0)) begin
      beat_next_s = beat_cnt_r - 5'd1;
    end else if (hready && is_idle_s) begin
      beat_next_s = 5'd0;
    end else begin
      beat_next_s = beat_cnt_r;
    end

    arb_en_s = hready && !is_busy_s && (state_next_s == GRANTED);
  end

  // Arbiter FSM with registered grant, ownership and lock outputs.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r      <= GRANTED;
      beat_cnt_r   <= 5'd0;
      rr_ptr_r     <= DEFAULT_IDX;
      hgrant       <= DEFAULT_GNT;
      hmaster      <= DEFAULT_IDX;
      hmaster_data <= DEFAULT_IDX;
      hmastlock    <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      beat_cnt_r <= beat_next_s;
      if (hready) begin
        hmaster      <= grant_idx_s;
        hmaster_data <= hmaster;
        hmastlock    <= lock_owner_s;
      end
      if (arb_en_s) begin
        if (win_found_s) begin
          hgrant   <= ONE_LSB << win_idx_s;
          rr_ptr_r <= win_idx_s;
        end else begin
          hgrant <= DEFAULT_GNT;
        end
      end
    end
  end

endmodule
